// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the command source / ALU / result sink and alu_cmd_sequencer.
// The sequencer uses the slave modport; the environment uses master.
interface alu_cmd_sequencer_if #(
    parameter int PTR_W = 2
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_sel;
    logic [3:0]     cmd_a;
    logic [3:0]     cmd_b;
    logic [2:0]     alu_sel;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic [7:0]     alu_y;
    logic           alu_par;
    logic           res_valid;
    logic           res_ready;
    logic [7:0]     res_data;
    logic           res_par;
    logic [2:0]     res_sel;
    logic [PTR_W:0] fifo_count;
    logic           busy;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, alu_par, res_ready,
        output cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_par, res_sel,
               fifo_count, busy
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, alu_par, res_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_par, res_sel,
               fifo_count, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture sequencer giving a combinational ALU a flow-controlled wrapper.
// Optional macro PARITY_CHECK_EN adds a sticky err_par output flagging alu_par != ^alu_y at capture.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus
`ifdef PARITY_CHECK_EN
    ,
    output logic               err_par
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    cmd_t             mem [DEPTH];
    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    cmd_t             alu_q, alu_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;
    logic             res_par_q, res_par_d;
    logic [2:0]       res_sel_q, res_sel_d;
`ifdef PARITY_CHECK_EN
    logic             err_par_q, err_par_d;
`endif

    logic full, push, pop, handshake;
    cmd_t cmd_in;

    assign cmd_in    = '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};
    assign full      = (count_q == CNT_FULL);
    // A pop in the same cycle does not free a slot for a push: cmd_ready sees only full.
    assign push      = bus.cmd_valid && !full;
    assign handshake = (state_q == HOLD) && res_valid_q && bus.res_ready;
    assign pop       = (count_q != '0) && ((state_q == IDLE) || handshake);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        alu_d       = alu_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_par_d   = res_par_q;
        res_sel_d   = res_sel_q;
`ifdef PARITY_CHECK_EN
        err_par_d   = err_par_q;
`endif

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            alu_d    = mem[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) state_d = ISSUE;
            end
            ISSUE: begin
                res_data_d  = bus.alu_y;
                res_par_d   = bus.alu_par;
                res_sel_d   = alu_q.sel;
                res_valid_d = 1'b1;
                state_d     = HOLD;
`ifdef PARITY_CHECK_EN
                if ((^bus.alu_y) != bus.alu_par) err_par_d = 1'b1;
`endif
            end
            HOLD: begin
                if (handshake) begin
                    res_valid_d = 1'b0;
                    state_d     = pop ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            alu_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_par_q   <= 1'b0;
            res_sel_q   <= '0;
`ifdef PARITY_CHECK_EN
            err_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alu_q       <= alu_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_par_q   <= res_par_d;
            res_sel_q   <= res_sel_d;
`ifdef PARITY_CHECK_EN
            err_par_q   <= err_par_d;
`endif
        end
    end

    // NOTE: storage is not reset; only the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cmd_in;
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_sel    = alu_q.sel;
    assign bus.alu_a      = alu_q.a;
    assign bus.alu_b      = alu_q.b;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_par    = res_par_q;
    assign bus.res_sel    = res_sel_q;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);
`ifdef PARITY_CHECK_EN
    assign err_par        = err_par_q;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: the bench plays the ALU and the result sink,
// predicting results from a queue of accepted commands.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [7:0] y;
        logic       par;
        logic [2:0] sel;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bad_par = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.PTR_W(PTR_W)) sif ();

`ifdef PARITY_CHECK_EN
    logic err_par;
`endif

    alu_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (sif)
`ifdef PARITY_CHECK_EN
        ,
        .err_par (err_par)
`endif
    );

    // Stand-in ALU: any fixed function works, the sequencer only transports its output.
    function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] aa, ab, amb;
        aa  = a + a;
        ab  = a + b;
        amb = a - b;
        case (s)
            3'd0:    alu_fn = {4'h0, amb};
            3'd1:    alu_fn = {4'h0, a} + {4'h0, b};
            3'd2:    alu_fn = {4'h0, a} * {4'h0, b};
            3'd3:    alu_fn = {aa, ab};
            3'd4:    alu_fn = {a & b, a | b};
            3'd5:    alu_fn = {a, b};
            3'd6:    alu_fn = {a ^ b, ~a};
            default: alu_fn = {b, a};
        endcase
    endfunction

    assign sif.alu_y   = alu_fn(sif.alu_sel, sif.alu_a, sif.alu_b);
    assign sif.alu_par = (^sif.alu_y) ^ bad_par;

    function automatic res_t model(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        res_t r;
        r.y   = alu_fn(s, a, b);
        r.par = (^r.y) ^ bad_par;
        r.sel = s;
        return r;
    endfunction

    res_t exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    int results  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record the push / result handshakes visible before the edge, then step.
    task automatic tick();
        res_t e;
        if (sif.cmd_valid && sif.cmd_ready) begin
            exp_q.push_back(model(sif.cmd_sel, sif.cmd_a, sif.cmd_b));
            accepted++;
        end
        if (sif.res_valid && sif.res_ready) begin
            results++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed=0x%0h expected=none", sif.res_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_data", sif.res_data, e.y);
                check("res_par", sif.res_par, e.par);
                check("res_sel", sif.res_sel, e.sel);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        sif.cmd_valid = 1'b0;
        sif.res_ready = 1'b1;
        while ((exp_q.size() != 0 || sif.busy) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_within_budget", n < max_cycles, 1);
    endtask

    task automatic set_cmd(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        sif.cmd_sel = s;
        sif.cmd_a   = a;
        sif.cmd_b   = b;
    endtask

    task automatic set_rand_cmd();
        set_cmd(3'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_res_valid"}, sif.res_valid, 0);
        check({tag, "_res_data"}, sif.res_data, 0);
        check({tag, "_res_par"}, sif.res_par, 0);
        check({tag, "_res_sel"}, sif.res_sel, 0);
        check({tag, "_alu_sel"}, sif.alu_sel, 0);
        check({tag, "_alu_a"}, sif.alu_a, 0);
        check({tag, "_alu_b"}, sif.alu_b, 0);
        check({tag, "_fifo_count"}, sif.fifo_count, 0);
        check({tag, "_busy"}, sif.busy, 0);
        check({tag, "_cmd_ready"}, sif.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, res0;

        sif.cmd_valid = 1'b0;
        sif.res_ready = 1'b0;
        set_cmd(3'd0, 4'd0, 4'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        tick();

        // Single command latency and capture
        sif.res_ready = 1'b1;
        set_cmd(3'b101, 4'h3, 4'h5);
        sif.cmd_valid = 1'b1;
        tick();
        sif.cmd_valid = 1'b0;
        check("t1_count_after_push", sif.fifo_count, 1);
        check("t1_no_valid_e0", sif.res_valid, 0);
        tick();
        check("t1_alu_sel", sif.alu_sel, 3'b101);
        check("t1_alu_a", sif.alu_a, 4'h3);
        check("t1_alu_b", sif.alu_b, 4'h5);
        check("t1_count_after_pop", sif.fifo_count, 0);
        check("t1_no_valid_e1", sif.res_valid, 0);
        tick();
        check("t1_valid_e2", sif.res_valid, 1);
        check("t1_data", sif.res_data, 8'h35);
        check("t1_par", sif.res_par, 0);
        check("t1_sel", sif.res_sel, 3'b101);
        tick();
        check("t1_valid_cleared", sif.res_valid, 0);
        check("t1_idle", sif.busy, 0);

        // Back-to-back commands, results two cycles apart
        set_cmd(3'b011, 4'h3, 4'h5);
        sif.cmd_valid = 1'b1;
        tick();
        set_cmd(3'b000, 4'hF, 4'hF);
        tick();
        sif.cmd_valid = 1'b0;
        tick();
        check("t2_first_valid", sif.res_valid, 1);
        check("t2_first_data", sif.res_data, 8'h68);
        check("t2_first_par", sif.res_par, 1);
        tick();
        check("t2_gap", sif.res_valid, 0);
        tick();
        check("t2_second_valid", sif.res_valid, 1);
        check("t2_second_data", sif.res_data, 8'h00);
        check("t2_second_par", sif.res_par, 0);
        tick();
        check("t2_done", sif.busy, 0);

        // Backpressure: 7 offers, DEPTH+1 accepted
        acc0 = accepted;
        sif.res_ready = 1'b0;
        sif.cmd_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_rand_cmd();
            tick();
        end
        sif.cmd_valid = 1'b0;
        check("t3_accepted", accepted - acc0, DEPTH + 1);
        check("t3_cmd_ready_full", sif.cmd_ready, 0);
        check("t3_count_full", sif.fifo_count, DEPTH);
        check("t3_holding", sif.res_valid, 1);
        res0 = results;
        drain(40);
        check("t3_results", results - res0, DEPTH + 1);
        check("t3_busy_after", sif.busy, 0);

        // Full FIFO, one handshake pop; a push in that cycle is refused
        acc0 = accepted;
        sif.res_ready = 1'b0;
        sif.cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rand_cmd();
            tick();
        end
        check("t4_full_before", sif.fifo_count, DEPTH);
        set_rand_cmd();
        sif.res_ready = 1'b1;
        tick();
        sif.cmd_valid = 1'b0;
        sif.res_ready = 1'b0;
        check("t4_count_after_pop", sif.fifo_count, DEPTH - 1);
        check("t4_cmd_ready_rises", sif.cmd_ready, 1);
        check("t4_push_refused", accepted - acc0, DEPTH + 1);
        check("t4_issue_no_valid", sif.res_valid, 0);
        drain(40);

        // Reset during ISSUE with 3 commands queued
        sif.res_ready = 1'b0;
        sif.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rand_cmd();
            tick();
        end
        set_rand_cmd();
        sif.res_ready = 1'b1;
        tick();
        sif.cmd_valid = 1'b0;
        check("t5_queued", sif.fifo_count, 3);
        check("t5_in_issue", sif.res_valid, 0);
        rst_n = 1'b0;
        #1;
        check_cleared("t5_async");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_result", sif.res_valid, 0);
        end
        check("t5_idle", sif.busy, 0);

`ifdef PARITY_CHECK_EN
        // Parity mismatch is sticky across later good results
        check("t6_err_clear", err_par, 0);
        bad_par = 1'b1;
        set_cmd(3'b000, 4'hF, 4'hF);
        sif.cmd_valid = 1'b1;
        tick();
        sif.cmd_valid = 1'b0;
        tick();
        tick();
        bad_par = 1'b0;
        check("t6_err_set", err_par, 1);
        check("t6_result_delivered", sif.res_valid, 1);
        set_cmd(3'b101, 4'h3, 4'h5);
        sif.cmd_valid = 1'b1;
        tick();
        drain(20);
        check("t6_err_sticky", err_par, 1);
        rst_n = 1'b0;
        #1;
        check("t6_err_reset", err_par, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
`endif

        // Randomized traffic against the queue model
        acc0 = accepted;
        res0 = results;
        for (int i = 0; i < 400; i++) begin
            sif.cmd_valid = ($urandom_range(0, 99) < 60);
            sif.res_ready = ($urandom_range(0, 99) < 50);
            set_rand_cmd();
            tick();
        end
        drain(100);
        check("rand_all_delivered", results - res0, accepted - acc0);
        check("rand_idle", sif.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 4-bit/3-bit-select ALU. Buffers operation commands {sel, A, B} in a small FIFO and drives them one at a time onto the ALU's combinational inputs. Captures the ALU's 8-bit result and parity, then presents them downstream with a valid/ready handshake. This gives the purely combinational ALU a registered, flow-controlled wrapper at system level.

Parameters:
DEPTH, 4, command FIFO entries; must be a power of two, minimum 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals !full.
cmd_sel  input  3  ALU operation select.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
alu_sel  output  3  registered select driven to the ALU.
alu_a  output  4  registered operand A driven to the ALU.
alu_b  output  4  registered operand B driven to the ALU.
alu_y  input  8  ALU result.
alu_par  input  1  ALU parity output (XOR of alu_y).
res_valid  output  1  result held for downstream.
res_ready  input  1  downstream accepts the result.
res_data  output  8  captured result.
res_par  output  1  captured parity.
res_sel  output  3  select that produced res_data.
fifo_count  output  PTR_W+1  FIFO occupancy, 0..DEPTH.
busy  output  1  high when the state is not IDLE or fifo_count != 0.

Behaviour:
- Reset (async assert, sync deassert at the next edge): state=IDLE, FIFO pointers and count=0; all registered outputs are 0 (alu_*, res_*, res_valid).
- Push: happens when cmd_valid && cmd_ready at a rising edge. cmd_ready depends only on full, so a full FIFO never accepts, even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): count is unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH.
- States:
  - IDLE: if count>0, pop the head into alu_sel/alu_a/alu_b and go to ISSUE; otherwise stay in IDLE.
  - ISSUE: a single settle cycle for the ALU. At the next edge, capture alu_y→res_data, alu_par→res_par, alu_sel→res_sel, set res_valid=1, and go to HOLD.
  - HOLD: res_* are stable while res_valid=1. On res_valid && res_ready:
    - if count>0, pop the next command into alu_* and go to ISSUE, with res_valid=0 in that cycle;
    - else clear res_valid and go to IDLE.
- alu_* keep the last issued command until the next pop. They are never changed in ISSUE or HOLD.
- Latency: a command pushed at edge E0 into an empty, idle block is popped at E1 and appears on res_valid at E2.
- Throughput: with res_ready held high, one result every 2 cycles.
- Backpressure: res_ready low holds HOLD indefinitely. The FIFO continues to accept up to DEPTH commands, so at most DEPTH+1 commands are in flight.
- Reset mid-operation: all in-flight and buffered commands are discarded and no result is emitted.
- No arithmetic is performed here; the ALU output width is preserved exactly (8 bits).

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - Adds output err_par (1 bit, reset 0).
  - At the ISSUE capture edge, the block recomputes XOR over alu_y and compares it with alu_par. A mismatch sets err_par.
  - err_par is sticky until rst_n; the result is still delivered.
- Undefined: no err_par port and no checking logic; alu_par is passed through unchanged.

Test Plan:
1. Reset, then push {sel=101, A=3, B=5}, res_ready=1 → res_valid high 2 edges after push; res_data=0x35, res_par=0, res_sel=101.
2. Push {011, A=3, B=5} then {000, A=F, B=F} back-to-back, res_ready=1 → results 0x68/par=1, then 0x00/par=0, with res_valid pulses 2 cycles apart.
3. res_ready=0, offer 7 consecutive commands → 5 accepted (1 in HOLD plus 4 buffered); cmd_ready=0 with fifo_count=4. Release res_ready → 5 results emitted in push order, then busy=0.
4. FIFO full, then res_ready pulsed for one HOLD handshake → fifo_count drops to 3 and cmd_ready rises the next cycle. A push in the pop cycle is refused.
5. Assert rst_n=0 during ISSUE with 3 commands queued → all outputs 0 immediately, fifo_count=0, no res_valid after release.
6. (PARITY_CHECK_EN) Force alu_par=1 while alu_y=0x00 → err_par=1 after capture and remains 1 through later correct results until reset.
